// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Define EX_MUL_EN to build in the iterative shift-add multiplier (op 111) and its busy stall.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] rg1,
  input  logic [31:0] rg2,
  input  logic [31:0] immVal,
  input  logic [4:0]  destReg,
  input  logic [4:0]  rdRg1,
  input  logic [4:0]  rdRg2,
  input  logic [2:0]  AluOperation,
  input  logic        AluSrc,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic        DataSrc,
  input  logic        WrReg,
  input  logic        zerocntrl,
  input  logic        memwbWrReg,
  input  logic [4:0]  memwbDest,
  input  logic [31:0] memwbData,
  output logic        busy,
  output logic [31:0] aluRes,
  output logic [31:0] wrData,
  output logic [4:0]  exmemDest,
  output logic        exmemMemWr,
  output logic        exmemMemRd,
  output logic        exmemDataSrc,
  output logic        exmemWrReg,
  output logic        exmemZero,
  output logic        exmemZerocntrl
);
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [31:0] aluRes_q, aluRes_d, wrData_q, wrData_d;
  logic [4:0]  dest_q, dest_d;
  logic [4:0]  ctl_q, ctl_d;  // {MemWr, MemRd, DataSrc, WrReg, zerocntrl}
  logic        zero_q, zero_d;
  logic [31:0] opA, opB, aluB, aluOut;
  logic [4:0]  ctlIn;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = {31'd0, (sa < sb)};
      3'b101:  alu = a ^ b;
      3'b110:  alu = ~(a | b);
      default: alu = 32'd0;
    endcase
  endfunction

  // Own EX/MEM result outranks MEM/WB; register 0 is never forwarded.
  assign ctlIn = {MemWr, MemRd, DataSrc, WrReg, zerocntrl};
  assign opA = (ctl_q[1] && dest_q != 5'd0 && dest_q == rdRg1) ? aluRes_q :
               (memwbWrReg && memwbDest != 5'd0 && memwbDest == rdRg1) ? memwbData : rg1;
  assign opB = (ctl_q[1] && dest_q != 5'd0 && dest_q == rdRg2) ? aluRes_q :
               (memwbWrReg && memwbDest != 5'd0 && memwbDest == rdRg2) ? memwbData : rg2;
  assign aluB   = AluSrc ? immVal : opB;
  assign aluOut = alu(AluOperation, opA, aluB);

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d, mcand_q, mcand_d, mplier_q, mplier_d;

  assign busy = !rst && !flush &&
                ((state_q == IDLE && AluOperation == OP_MUL) || state_q == MUL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    aluRes_d = 32'd0;
    wrData_d = 32'd0;
    dest_d   = 5'd0;
    ctl_d    = 5'd0;
    zero_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (AluOperation == OP_MUL) begin
          mcand_d  = opA;
          mplier_d = opB;
          prod_d   = 32'd0;
          cnt_d    = 5'd0;
          state_d  = MUL;
        end else begin
          aluRes_d = aluOut;
          wrData_d = opB;
          dest_d   = destReg;
          ctl_d    = ctlIn;
          zero_d   = (aluOut == 32'd0);
        end
      end
      MUL: begin
        // Multiplier stays unshifted so it doubles as the captured store data.
        if (mplier_q[cnt_q]) prod_d = prod_q + (mcand_q << cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        aluRes_d = prod_q;
        wrData_d = mplier_q;
        dest_d   = destReg;
        ctl_d    = ctlIn;
        zero_d   = (prod_q == 32'd0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      prod_q  <= 32'd0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end
`else
  assign busy = 1'b0;

  always_comb begin
    aluRes_d = aluOut;
    wrData_d = opB;
    dest_d   = destReg;
    ctl_d    = ctlIn;
    zero_d   = (aluOut == 32'd0);
  end
`endif

  // EX/MEM boundary: reset and flush both load a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      aluRes_q <= 32'd0;
      wrData_q <= 32'd0;
      dest_q   <= 5'd0;
      ctl_q    <= 5'd0;
      zero_q   <= 1'b0;
    end else begin
      aluRes_q <= aluRes_d;
      wrData_q <= wrData_d;
      dest_q   <= dest_d;
      ctl_q    <= ctl_d;
      zero_q   <= zero_d;
    end
  end

  assign aluRes         = aluRes_q;
  assign wrData         = wrData_q;
  assign exmemDest      = dest_q;
  assign exmemMemWr     = ctl_q[4];
  assign exmemMemRd     = ctl_q[3];
  assign exmemDataSrc   = ctl_q[2];
  assign exmemWrReg     = ctl_q[1];
  assign exmemZerocntrl = ctl_q[0];
  assign exmemZero      = zero_q;
endmodule
